// File: rtl/tempsens_multi_readout.sv
// Multi-channel delay-sensor readout: round-robin precharge/measure, averaging, per-channel bank, 7-seg digit.
// Optional feature macro: TEMPSENS_PWM_EN adds a registered PWM of the selected channel's result.

module tempsens_sync_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

module tempsens_multi_readout #(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 12,
    parameter int PRECHARGE_CYC = 8,
    parameter int AVG_LOG2      = 2,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              EN,
    input  logic [CH_W-1:0]   CH_SEL,
    output logic [NUM_CH-1:0] SENSE_PRECHG,
    input  logic [NUM_CH-1:0] SENSE_DONE,
    output logic [CNT_W-1:0]  RESULT,
    output logic [CH_W-1:0]   RESULT_CH,
    output logic              RESULT_VALID,
    output logic              TIMEOUT,
    output logic [6:0]        LEDDISP,
    output logic              PWM_OUT
);
    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int NS_W  = AVG_LOG2 + 1;
    localparam int PC_W  = (PRECHARGE_CYC > 1) ? $clog2(PRECHARGE_CYC) : 1;
    localparam logic [NS_W-1:0] NS_LAST  = NS_W'((1 << AVG_LOG2) - 1);
    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(PRECHARGE_CYC - 1);
    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]   NUM_CH_V = (CH_W + 1)'(NUM_CH);
    // Without PWM only the displayed top nibble of each result is ever read back.
`ifdef TEMPSENS_PWM_EN
    localparam int BANK_LSB = 0;
`else
    localparam int BANK_LSB = CNT_W - 4;
`endif
    localparam int BANK_W = CNT_W - BANK_LSB;

    typedef enum logic [1:0] {S_IDLE, S_PRECHG, S_MEASURE, S_STORE} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] value;
        logic [CH_W-1:0]  ch;
        logic             timeout;
    } res_t;

    state_t                         state, state_nxt;
    logic [CH_W-1:0]                ch, ch_inc;
    logic [PC_W-1:0]                pre_cnt;
    logic [CNT_W-1:0]               cnt, sample, avg_val;
    logic [ACC_W-1:0]               acc, acc_sum;
    logic [NS_W-1:0]                nsamp;
    logic                           to_flag;
    res_t                           res_q;
    logic                           res_vld;
    logic [NUM_CH-1:0][BANK_W-1:0]  bank;
    logic [NUM_CH-1:0]              done_sync;
    logic                           done_act, cnt_max, pre_last, avg_done;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
        tempsens_sync_cell u_sync (
            .clk   (CLK),
            .rst_n (RESET_N),
            .d     (SENSE_DONE[i]),
            .q     (done_sync[i])
        );
    end

    assign done_act = done_sync[ch];
    assign cnt_max  = &cnt;
    assign pre_last = (pre_cnt == PC_LAST);
    assign acc_sum  = acc + ACC_W'(sample);
    assign avg_val  = acc_sum[ACC_W-1 -: CNT_W];
    assign avg_done = (nsamp == NS_LAST);
    assign ch_inc   = (ch == CH_LAST) ? '0 : ch + 1'b1;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (EN) state_nxt = S_PRECHG;
            S_PRECHG:  if (!EN) state_nxt = S_IDLE;
                       else if (pre_last) state_nxt = S_MEASURE;
            S_MEASURE: if (!EN) state_nxt = S_IDLE;
                       else if (done_act || cnt_max) state_nxt = S_STORE;
            S_STORE:   state_nxt = EN ? S_PRECHG : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        SENSE_PRECHG = '0;
        if (state == S_PRECHG) SENSE_PRECHG[ch] = 1'b1;
    end

    // Any visit to IDLE drops a partial average so the channel restarts from sample 0.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ch      <= '0;
            pre_cnt <= '0;
            cnt     <= '0;
            sample  <= '0;
            acc     <= '0;
            nsamp   <= '0;
            to_flag <= 1'b0;
            res_q   <= '0;
            res_vld <= 1'b0;
            bank    <= '0;
        end else begin
            res_vld <= 1'b0;
            pre_cnt <= (state == S_PRECHG && state_nxt == S_PRECHG) ? pre_cnt + 1'b1 : '0;
            case (state)
                S_IDLE: begin
                    acc     <= '0;
                    nsamp   <= '0;
                    to_flag <= 1'b0;
                end
                S_PRECHG: cnt <= '0;
                S_MEASURE: begin
                    if (done_act) begin
                        sample <= cnt;
                    end else if (cnt_max) begin
                        sample  <= '1;
                        to_flag <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STORE: begin
                    if (avg_done) begin
                        res_q    <= '{value: avg_val, ch: ch, timeout: to_flag};
                        res_vld  <= 1'b1;
                        bank[ch] <= avg_val[CNT_W-1:BANK_LSB];
                        acc      <= '0;
                        nsamp    <= '0;
                        to_flag  <= 1'b0;
                        ch       <= ch_inc;
                    end else begin
                        acc   <= acc_sum;
                        nsamp <= nsamp + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign RESULT       = res_q.value;
    assign RESULT_CH    = res_q.ch;
    assign TIMEOUT      = res_q.timeout;
    assign RESULT_VALID = res_vld;

    function automatic logic [6:0] seg7(input logic [3:0] h);
        case (h)
            4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
        endcase
    endfunction

    logic              sel_ok;
    logic [BANK_W-1:0] sel_bank;

    assign sel_ok   = ({1'b0, CH_SEL} < NUM_CH_V);
    assign sel_bank = sel_ok ? bank[CH_SEL] : '0;
    assign LEDDISP  = sel_ok ? seg7(sel_bank[BANK_W-1 -: 4]) : 7'h00;

`ifdef TEMPSENS_PWM_EN
    logic [CNT_W-1:0] pwm_cnt;
    logic             pwm_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pwm_cnt <= '0;
            pwm_q   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            pwm_q   <= (pwm_cnt < sel_bank);
        end
    end

    assign PWM_OUT = pwm_q;
`else
    assign PWM_OUT = 1'b0;
`endif
endmodule

// File: tb/tb_tempsens_multi_readout.sv
// Directed bench for tempsens_multi_readout: behavioural sensor cells, result-queue model, literal pins.
module tb_tempsens_multi_readout;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] ch_sel = 2'd0;
    logic [3:0] prechg;
    logic [3:0] sense_done = 4'd0;
    logic [7:0] result;
    logic [1:0] result_ch;
    logic       result_valid, timeout_o, pwm_out;
    logic [6:0] leddisp;

    tempsens_multi_readout #(
        .NUM_CH(4), .CNT_W(8), .PRECHARGE_CYC(4), .AVG_LOG2(2)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .EN(en), .CH_SEL(ch_sel),
        .SENSE_PRECHG(prechg), .SENSE_DONE(sense_done),
        .RESULT(result), .RESULT_CH(result_ch), .RESULT_VALID(result_valid),
        .TIMEOUT(timeout_o), .LEDDISP(leddisp), .PWM_OUT(pwm_out)
    );

    always #5 clk = ~clk;

    typedef struct packed { int value; int ch; int to; } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t expq[$];
    int   delay_tab[4][4];
    bit   idle_expect = 1'b1;
    int   mbank[4];
    int   exp_res = 0, exp_ch = 0, exp_to = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hex_seg(input int v);
        int tab[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                        'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
        return tab[v & 15];
    endfunction

    // A sample is one more than the DONE delay, saturating at 255 with a timeout from k=255 up.
    function automatic exp_t conv_result(input int c);
        exp_t e;
        int   sum = 0;
        int   to = 0;
        for (int s = 0; s < 4; s++) begin
            if (delay_tab[c][s] <= 254) sum += delay_tab[c][s] + 1;
            else begin
                sum += 255;
                to = 1;
            end
        end
        e.value = sum / 4;
        e.ch    = c;
        e.to    = to;
        return e;
    endfunction

    task automatic push_exp(input int c);
        expq.push_back(conv_result(c));
    endtask

    task automatic set_delays(input int c, input int k0, input int k1, input int k2, input int k3);
        delay_tab[c][0] = k0;
        delay_tab[c][1] = k1;
        delay_tab[c][2] = k2;
        delay_tab[c][3] = k3;
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        while (n < bound) begin
            @(negedge clk);
            n++;
            if (result_valid) return;
        end
        chk("valid_wait_expired", 0, 1);
    endtask

    // Sensor cells: DONE low while precharged, rises k negedges after precharge ends.
    initial begin
        int t[4];
        int cur_k[4];
        int pc[4];
        bit armed[4];
        bit in_pre[4];
        for (int i = 0; i < 4; i++) begin
            t[i] = 0; cur_k[i] = 0; pc[i] = 0; armed[i] = 0; in_pre[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (prechg[i]) begin
                    if (!in_pre[i]) begin
                        cur_k[i] = delay_tab[i][pc[i] % 4];
                        pc[i]++;
                    end
                    in_pre[i] = 1;
                    armed[i] = 1;
                    t[i] = 0;
                    sense_done[i] = 1'b0;
                end else begin
                    in_pre[i] = 0;
                    if (armed[i]) begin
                        t[i]++;
                        if (t[i] == cur_k[i]) sense_done[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Compare process: result registers, bank-driven display, precharge legality.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) mbank[i] = 0;
                exp_res = 0; exp_ch = 0; exp_to = 0;
            end else if (result_valid) begin
                if (expq.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    e = expq.pop_front();
                    exp_res = e.value; exp_ch = e.ch; exp_to = e.to;
                    mbank[e.ch] = e.value;
                end
            end
            if (!rst_n) chk("valid_in_reset", int'(result_valid), 0);
            chk("result", int'(result), exp_res);
            chk("result_ch", int'(result_ch), exp_ch);
            chk("timeout", int'(timeout_o), exp_to);
            chk("leddisp", int'(leddisp), hex_seg(mbank[ch_sel] >> 4));
            chk("prechg_onehot", int'($countones(prechg) <= 1), 1);
            if (idle_expect || !rst_n) chk("prechg_idle", int'(prechg), 0);
`ifndef TEMPSENS_PWM_EN
            chk("pwm_off", int'(pwm_out), 0);
`endif
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int falls;
        bit prev;
        int highs;
        for (int c = 0; c < 4; c++) set_delays(c, 0, 0, 0, 0);

        // reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_led", int'(leddisp), 'h3F);
        chk("idle_result", int'(result), 0);
        chk("idle_valid", int'(result_valid), 0);
        chk("idle_prechg", int'(prechg), 0);

        // round robin: ch0 basic, ch1 truncation, ch2 timeout, ch3 normal, wrap to ch0
        set_delays(0, 50, 50, 50, 50);
        set_delays(1, 49, 50, 51, 52);
        set_delays(2, 100000, 100000, 100000, 100000);
        set_delays(3, 20, 20, 20, 20);
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
        idle_expect = 1'b0;
        en = 1'b1;
        wait_valid(400, n);
        chk("first_latency", n, 229);
        chk("ch0_result", int'(result), 51);
        chk("ch0_ch", int'(result_ch), 0);
        chk("next_prechg", int'(prechg), 'b0010);
        wait_valid(400, n);
        chk("ch1_trunc", int'(result), 51);
        chk("ch1_ch", int'(result_ch), 1);
        wait_valid(1300, n);
        chk("ch2_sat", int'(result), 255);
        chk("ch2_timeout", int'(timeout_o), 1);
        wait_valid(400, n);
        chk("ch3_result", int'(result), 21);
        chk("ch3_timeout", int'(timeout_o), 0);
        set_delays(1, 40, 40, 40, 40);
        wait_valid(400, n);
        chk("wrap_ch", int'(result_ch), 0);

        // abort ch1 during the MEASURE of its fourth sample
        falls = 0;
        prev = prechg[1];
        for (int c = 0; c < 600 && falls < 4; c++) begin
            @(negedge clk);
            if (prev && !prechg[1]) falls++;
            prev = prechg[1];
        end
        chk("abort_reached_s3", falls, 4);
        repeat (10) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        idle_expect = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_hold", int'(result), 51);
        idle_expect = 1'b0;
        push_exp(1);
        en = 1'b1;
        wait_valid(400, n);
        chk("restart_latency", n, 189);
        chk("restart_result", int'(result), 41);

        // asynchronous reset during ch2 precharge
        chk("pre_reset_prechg", int'(prechg), 'b0100);
        #3 rst_n = 1'b0;
        #1;
        chk("async_prechg", int'(prechg), 0);
        chk("async_result", int'(result), 0);
        chk("async_led", int'(leddisp), 'h3F);
        en = 1'b0;
        idle_expect = 1'b1;
        repeat (3) @(negedge clk);
        set_delays(0, 179, 179, 179, 179);
        rst_n = 1'b1;
        @(negedge clk);

        // display and PWM on a 0xB4 result
        idle_expect = 1'b0;
        push_exp(0);
        en = 1'b1;
        wait_valid(1500, n);
        chk("b4_latency", n, 745);
        chk("b4_result", int'(result), 180);
        en = 1'b0;
        repeat (3) @(negedge clk);
        idle_expect = 1'b1;
        ch_sel = 2'd0;
        @(negedge clk);
        chk("led_b", int'(leddisp), 'h7C);
        ch_sel = 2'd1;
        @(negedge clk);
        chk("led_unconverted", int'(leddisp), 'h3F);
        ch_sel = 2'd0;
        repeat (3) @(negedge clk);
        highs = 0;
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            highs += int'(pwm_out);
        end
`ifdef TEMPSENS_PWM_EN
        chk("pwm_duty", highs, 180);
`else
        chk("pwm_duty", highs, 0);
`endif
        chk("queue_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
